// File: rtl/key_extract_mt.sv
// key_extract_mt: multi-tenant match-key extractor for one match-action stage.
// A per-tenant offset entry, looked up by the PHV VLAN ID, selects which
// 6B/4B/2B containers form the key. The PHV passes through unchanged.
// Two-stage valid/ready pipeline:
//   S1 holds the PHV and its table entry.
//   S2 holds the PHV, the key and the output valid.
// Build option KEY_EXTRACT_CMP_EN: when defined, the comparator ops selected by
// CMP_MASK drive key bits [4:0]. When undefined, those bits are always zero.
module key_extract_mt #(
    parameter int          STAGE              = 0,
    parameter int          N_6B               = 2,
    parameter int          N_4B               = 2,
    parameter int          N_2B               = 2,
    parameter int unsigned CMP_MASK           = 5'b00001 << (4 - STAGE),
    parameter int          PHV_LEN            = 1124,
    parameter int          KEY_LEN            = 48*N_6B + 32*N_4B + 16*N_2B + 5,
    parameter int          KEY_OFF            = 3*(N_6B + N_4B + N_2B),
    parameter int          AXIL_WIDTH         = 32,
    parameter int          KEY_OFF_ADDR_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PHV_LEN-1:0]            phv_in,
    input  logic                          phv_valid_in,
    output logic                          phv_ready_out,
    input  logic [AXIL_WIDTH-1:0]         key_off_entry_in,
    input  logic                          key_off_entry_in_valid,
    input  logic [KEY_OFF_ADDR_WIDTH-1:0] key_off_entry_addr,
    output logic [PHV_LEN-1:0]            phv_out,
    output logic                          phv_valid_out,
    input  logic                          phv_ready_in,
    output logic [KEY_LEN-1:0]            key_out,
    output logic                          key_valid_out
);

    // PHV layout, from the MSB down:
    //   eight 6B containers
    //   eight 4B containers
    //   eight 2B containers
    //   five 20-bit comparator ops
    //   metadata
    localparam int C6_LSB    = PHV_LEN - 8*48;
    localparam int C4_LSB    = C6_LSB - 8*32;
    localparam int C2_LSB    = C4_LSB - 8*16;
    localparam int OP_MSB    = C2_LSB - 1;
    localparam int IDX_LSB   = 133;
    localparam int ENT_W     = KEY_OFF + 1;
    localparam int TBL_DEPTH = 1 << KEY_OFF_ADDR_WIDTH;

    if (KEY_OFF + 1 > AXIL_WIDTH) begin : g_bad_key_off
        $error("key_extract_mt: offset entry does not fit in AXIL_WIDTH");
    end
    if (STAGE < 0 || STAGE > 4) begin : g_bad_stage
        $error("key_extract_mt: STAGE must be 0..4");
    end
    if (CMP_MASK > 31) begin : g_bad_mask
        $error("key_extract_mt: CMP_MASK is a 5-bit mask");
    end
    if (N_6B < 1 || N_6B > 4 || N_4B < 1 || N_4B > 4 || N_2B < 1 || N_2B > 4) begin : g_bad_n
        $error("key_extract_mt: container counts must be 1..4");
    end
    if (AXIL_WIDTH > ENT_W) begin : g_spare_bits
        logic unused_entry_bits;
        assign unused_entry_bits = ^key_off_entry_in[AXIL_WIDTH-1:ENT_W];
    end

    logic [ENT_W-1:0]   tbl_q [TBL_DEPTH];
    logic [ENT_W-1:0]   tbl_d [TBL_DEPTH];
    logic               s1_valid_q, s1_valid_d;
    logic [PHV_LEN-1:0] s1_phv_q, s1_phv_d;
    logic [ENT_W-1:0]   s1_entry_q, s1_entry_d;
    logic               out_valid_q, out_valid_d;
    logic [PHV_LEN-1:0] phv_out_q, phv_out_d;
    logic [KEY_LEN-1:0] key_out_q, key_out_d;
    logic [KEY_LEN-1:0] key_calc;
    logic [4:0]         cmp_bits;
    logic [2:0]         off;
    logic               s1_adv, s2_adv;

    assign s2_adv        = ~out_valid_q | phv_ready_in;
    assign s1_adv        = ~s1_valid_q | s2_adv;
    assign phv_ready_out = s1_adv;
    assign phv_valid_out = out_valid_q;
    assign key_valid_out = out_valid_q;
    assign phv_out       = phv_out_q;
    assign key_out       = key_out_q;

    // Offset table write. The S1 lookup reads tbl_q, so a lookup on the same edge sees the old entry.
    always_comb begin
        tbl_d = tbl_q;
        if (key_off_entry_in_valid) begin
            tbl_d[key_off_entry_addr] = key_off_entry_in[ENT_W-1:0];
        end
    end

    // S1 capture: the PHV and its tenant entry. The stage holds while stalled.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_phv_d   = s1_phv_q;
        s1_entry_d = s1_entry_q;
        if (s1_adv) begin
            s1_valid_d = phv_valid_in;
            if (phv_valid_in) begin
                s1_phv_d   = phv_in;
                s1_entry_d = tbl_q[phv_in[IDX_LSB +: KEY_OFF_ADDR_WIDTH]];
            end
        end
    end

`ifdef KEY_EXTRACT_CMP_EN
    // Operand fetch: an 8-bit immediate, or the low byte of an indexed container.
    function automatic logic [7:0] cmp_operand(input logic [8:0] fld, input logic [PHV_LEN-1:0] phv);
        logic [7:0] val;
        val = 8'h00;
        if (fld[8]) begin
            val = fld[7:0];
        end else begin
            case (fld[4:3])
                2'b10:   val = phv[C6_LSB + 48*int'(fld[2:0]) +: 8];
                2'b01:   val = phv[C4_LSB + 32*int'(fld[2:0]) +: 8];
                2'b00:   val = phv[C2_LSB + 16*int'(fld[2:0]) +: 8];
                default: val = 8'h00;
            endcase
        end
        return val;
    endfunction

    logic [19:0] op_fld;
    logic [7:0]  opnd_a, opnd_b;

    // Evaluate each op enabled in CMP_MASK. Op i drives key bit 4-i.
    always_comb begin
        cmp_bits = '0;
        op_fld   = '0;
        opnd_a   = '0;
        opnd_b   = '0;
        for (int i = 0; i < 5; i++) begin
            if (((CMP_MASK >> i) & 1) != 0) begin
                op_fld = s1_phv_q[OP_MSB - 20*i -: 20];
                opnd_a = cmp_operand(op_fld[17:9], s1_phv_q);
                opnd_b = cmp_operand(op_fld[8:0], s1_phv_q);
                case (op_fld[19:18])
                    2'b00:   cmp_bits[4-i] = (opnd_a > opnd_b);
                    2'b01:   cmp_bits[4-i] = (opnd_a >= opnd_b);
                    2'b10:   cmp_bits[4-i] = (opnd_a == opnd_b);
                    default: cmp_bits[4-i] = 1'b1;
                endcase
            end
        end
    end
`else
    assign cmp_bits = 5'b00000;
`endif

    // Key assembly from the S1 entry. The offsets are read MSB-first: 6B, then 4B, then 2B.
    always_comb begin
        key_calc = '0;
        off      = '0;
        for (int k = 0; k < N_6B; k++) begin
            off = s1_entry_q[KEY_OFF-1-3*k -: 3];
            key_calc[KEY_LEN-1-48*k -: 48] = s1_phv_q[C6_LSB + 48*int'(off) +: 48];
        end
        for (int k = 0; k < N_4B; k++) begin
            off = s1_entry_q[KEY_OFF-1-3*(N_6B+k) -: 3];
            key_calc[KEY_LEN-1-48*N_6B-32*k -: 32] = s1_phv_q[C4_LSB + 32*int'(off) +: 32];
        end
        for (int k = 0; k < N_2B; k++) begin
            off = s1_entry_q[KEY_OFF-1-3*(N_6B+N_4B+k) -: 3];
            key_calc[KEY_LEN-1-48*N_6B-32*N_4B-16*k -: 16] = s1_phv_q[C2_LSB + 16*int'(off) +: 16];
        end
        if (!s1_entry_q[KEY_OFF]) begin
            key_calc = '0;
        end
        key_calc[4:0] = cmp_bits;
    end

    // S2 output register. The stage advances when it is empty or downstream is ready.
    always_comb begin
        out_valid_d = out_valid_q;
        phv_out_d   = phv_out_q;
        key_out_d   = key_out_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                phv_out_d = s1_phv_q;
                key_out_d = key_calc;
            end
        end
    end

    // State registers. Reset clears the pipeline and the offset table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
            s1_valid_q  <= 1'b0;
            s1_phv_q    <= '0;
            s1_entry_q  <= '0;
            out_valid_q <= 1'b0;
            phv_out_q   <= '0;
            key_out_q   <= '0;
        end else begin
            tbl_q       <= tbl_d;
            s1_valid_q  <= s1_valid_d;
            s1_phv_q    <= s1_phv_d;
            s1_entry_q  <= s1_entry_d;
            out_valid_q <= out_valid_d;
            phv_out_q   <= phv_out_d;
            key_out_q   <= key_out_d;
        end
    end

endmodule
